// File: rtl/mem_resp_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_arbiter_pkg
// Shared definitions for the memory response arbiter: FSM state encoding,
// client identifiers and the round-robin pick function.
// ---------------------------------------------------------------------------
package mem_resp_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic CLIENT_ICACHE = 1'b0;
    localparam logic CLIENT_DCACHE = 1'b1;

    // A lone requester wins outright. On a tie the client that did not win
    // last time wins, so with last_grant = 0 out of reset the first tie
    // goes to the dcache.
    function automatic logic rr_pick(input logic req0,
                                     input logic req1,
                                     input logic last_grant);
        if (req0 && req1) begin
            return ~last_grant;
        end else if (req1) begin
            return CLIENT_DCACHE;
        end else begin
            return CLIENT_ICACHE;
        end
    endfunction

endpackage

// File: rtl/mem_resp_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_resp_arbiter_if
// Bundles the two client request/response channels and the shared memory
// port into one bus.
//   slave  : view used by the arbiter (consumes client requests and memory
//            responses, produces acks, response line and memory request).
//   master : view used by the surrounding environment (caches + memory).
// Signals:
//   req0/1, addr0/1, we0/1, wdata0/1 : client requests
//   ack0/1, err, route_sel, resp_data : client completion + demux drive
//   mem_req, mem_addr, mem_we, mem_wdata : memory request
//   mem_ready, mem_rdata : memory completion
// ---------------------------------------------------------------------------
interface mem_resp_arbiter_if #(
    parameter int N      = 128,
    parameter int ADDR_W = 32
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              we0;
    logic              we1;
    logic [N-1:0]      wdata0;
    logic [N-1:0]      wdata1;

    logic              ack0;
    logic              ack1;
    logic              err;
    logic              route_sel;
    logic [N-1:0]      resp_data;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [N-1:0]      mem_wdata;
    logic              mem_ready;
    logic [N-1:0]      mem_rdata;

    modport slave (
        input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1,
        input  mem_ready, mem_rdata,
        output ack0, ack1, err, route_sel, resp_data,
        output mem_req, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1,
        output mem_ready, mem_rdata,
        input  ack0, ack1, err, route_sel, resp_data,
        input  mem_req, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/mem_timeout_counter.sv
// ---------------------------------------------------------------------------
// mem_timeout_counter
// Counts cycles spent waiting on memory and flags the last allowed cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (takes priority over i_en)
//   i_en       : increment this cycle
//   o_expired  : count has reached TIMEOUT-1 (never set when TIMEOUT = 0)
// ---------------------------------------------------------------------------
module mem_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    // TIMEOUT = 0 would give a zero-width counter; keep one dummy bit.
    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] C_LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired = (TIMEOUT != 0) && (r_count == C_LAST);

endmodule

// File: rtl/mem_resp_arbiter.sv
// ---------------------------------------------------------------------------
// mem_resp_arbiter
// Shares one memory port between the icache (client 0) and dcache
// (client 1). Round-robin grant, a single outstanding transaction, and an
// optional bounded wait on memory. The returned line and the owner id are
// registered and drive the 1-to-2 response demux in front of the caches.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_resp_arbiter_if.slave (client channels + memory port)
// Parameters:
//   N       : line width
//   ADDR_W  : address width
//   TIMEOUT : max BUSY cycles without mem_ready; 0 disables the timeout
// ---------------------------------------------------------------------------
module mem_resp_arbiter
    import mem_resp_arbiter_pkg::*;
#(
    parameter int N       = 128,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_resp_arbiter_if.slave     bus
);

    state_t            r_state;
    logic              r_last_grant;
    logic              r_route_sel;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_err;
    logic [N-1:0]      r_resp_data;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [N-1:0]      r_mem_wdata;

    logic              w_grant_valid;
    logic              w_grant_owner;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_expired;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_owner = CLIENT_ICACHE;
        if (r_state == ST_IDLE) begin
            w_grant_valid = bus.req0 | bus.req1;
            w_grant_owner = rr_pick(bus.req0, bus.req1, r_last_grant);
        end
    end

    // Holding the counter clear throughout IDLE means it starts at zero on
    // the first BUSY cycle of every transaction.
    assign w_cnt_clr = (r_state == ST_IDLE);
    assign w_cnt_en  = (r_state == ST_BUSY);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide datapath registers are reset too because the
            // demux input and memory port must read 0 straight out of
            // reset, including after an aborted transaction.
            r_state      <= ST_IDLE;
            r_last_grant <= CLIENT_ICACHE;
            r_route_sel  <= CLIENT_ICACHE;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err        <= 1'b0;
            r_resp_data  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_route_sel  <= w_grant_owner;
                        r_last_grant <= w_grant_owner;
                        r_mem_addr   <= w_grant_owner ? bus.addr1  : bus.addr0;
                        r_mem_we     <= w_grant_owner ? bus.we1    : bus.we0;
                        r_mem_wdata  <= w_grant_owner ? bus.wdata1 : bus.wdata0;
                        r_mem_req    <= 1'b1;
                        r_state      <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    // mem_ready is checked first so a completion on the
                    // expiry cycle is reported as a clean response.
                    if (bus.mem_ready) begin
                        if (!r_mem_we) begin
                            r_resp_data <= bus.mem_rdata;
                        end
                        r_mem_req <= 1'b0;
                        r_ack0    <= (r_route_sel == CLIENT_ICACHE);
                        r_ack1    <= (r_route_sel == CLIENT_DCACHE);
                        r_state   <= ST_DONE;
                    end else if (w_expired) begin
                        r_resp_data <= '0;
                        r_err       <= 1'b1;
                        r_mem_req   <= 1'b0;
                        r_ack0      <= (r_route_sel == CLIENT_ICACHE);
                        r_ack1      <= (r_route_sel == CLIENT_DCACHE);
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // No grant here: the acked client's req is still high
                    // this cycle and must not start a second transaction.
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.err       = r_err;
    assign bus.route_sel = r_route_sel;
    assign bus.resp_data = r_resp_data;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_resp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_resp_arbiter
// Directed self-checking bench for mem_resp_arbiter (TIMEOUT = 4).
// Inputs change and outputs are observed 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mem_resp_arbiter;

    localparam int N       = 128;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] exp_resp;

    mem_resp_arbiter_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

    mem_resp_arbiter #(
        .N       (N),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_tests++; if (bus.mem_req   !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_tests++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b%b%b want 000", bus.ack0, bus.ack1, bus.err); end
        n_tests++; if (bus.route_sel !== 1'b0) begin n_fail++; $display("FAIL reset_route_sel: got %b want 0", bus.route_sel); end
        n_tests++; if (bus.resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); end
        n_tests++; if (bus.mem_addr !== '0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_port: got addr %h we %b want 0 0", bus.mem_addr, bus.mem_we); end
        rst_n = 1'b1;
        tick();
        exp_resp = '0;
    endtask

    task automatic test_round_robin();
        logic         exp_owner;
        logic [N-1:0] rd;
        bit           got;
        bus.addr0 = 32'h0000_1000;
        bus.addr1 = 32'h0000_2000;
        bus.we0   = 1'b0;
        bus.we1   = 1'b0;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_owner = (i % 2 == 0) ? 1'b1 : 1'b0;
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                tick();
                if (bus.mem_req === 1'b1) got = 1'b1;
            end
            n_tests++; if (!got) begin n_fail++; $display("FAIL rr_grant_wait[%0d]: got no mem_req want mem_req within 8 cycles", i); end
            n_tests++; if (bus.route_sel !== exp_owner) begin n_fail++; $display("FAIL rr_owner[%0d]: got %b want %b", i, bus.route_sel, exp_owner); end
            n_tests++; if (bus.mem_addr !== (exp_owner ? 32'h0000_2000 : 32'h0000_1000)) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", i, bus.mem_addr, exp_owner ? 32'h0000_2000 : 32'h0000_1000); end
            rd = {4{32'hC0DE_0000 | 32'(i)}};
            bus.mem_rdata = rd;
            bus.mem_ready = 1'b1;
            tick();
            bus.mem_ready = 1'b0;
            exp_resp = rd;
            n_tests++; if (bus.ack0 !== ~exp_owner || bus.ack1 !== exp_owner) begin n_fail++; $display("FAIL rr_ack[%0d]: got ack0 %b ack1 %b want %b %b", i, bus.ack0, bus.ack1, ~exp_owner, exp_owner); end
            n_tests++; if (bus.resp_data !== exp_resp) begin n_fail++; $display("FAIL rr_resp[%0d]: got %h want %h", i, bus.resp_data, exp_resp); end
            n_tests++; if (bus.err !== 1'b0 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rr_done_state[%0d]: got err %b mem_req %b want 0 0", i, bus.err, bus.mem_req); end
            if (i == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            tick();
            // The DONE cycle must not have granted anything.
            n_tests++; if (bus.mem_req !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin n_fail++; $display("FAIL rr_no_grant_in_done[%0d]: got mem_req %b ack %b%b want 0 00", i, bus.mem_req, bus.ack0, bus.ack1); end
        end
    endtask

    task automatic test_write();
        bus.addr1  = 32'h0000_3000;
        bus.we1    = 1'b1;
        bus.wdata1 = {16{8'hA5}};
        bus.req1   = 1'b1;
        tick();
        n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL write_req_we: got %b %b want 1 1", bus.mem_req, bus.mem_we); end
        n_tests++; if (bus.mem_wdata !== {16{8'hA5}}) begin n_fail++; $display("FAIL write_wdata: got %h want %h", bus.mem_wdata, {16{8'hA5}}); end
        n_tests++; if (bus.mem_addr !== 32'h0000_3000 || bus.route_sel !== 1'b1) begin n_fail++; $display("FAIL write_addr_owner: got %h %b want 00003000 1", bus.mem_addr, bus.route_sel); end
        bus.mem_rdata = {4{32'hBAAD_F00D}};
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.req1      = 1'b0;
        bus.we1       = 1'b0;
        n_tests++; if (bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL write_ack: got ack0 %b ack1 %b err %b want 0 1 0", bus.ack0, bus.ack1, bus.err); end
        n_tests++; if (bus.resp_data !== exp_resp) begin n_fail++; $display("FAIL write_resp_hold: got %h want %h", bus.resp_data, exp_resp); end
        tick();
    endtask

    task automatic test_single_read();
        bus.addr0 = 32'h0000_0100;
        bus.we0   = 1'b0;
        bus.req0  = 1'b1;
        tick();
        n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL read_issue: got mem_req %b addr %h want 1 00000100", bus.mem_req, bus.mem_addr); end
        n_tests++; if (bus.route_sel !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL read_owner_we: got %b %b want 0 0", bus.route_sel, bus.mem_we); end
        tick();
        tick();
        n_tests++; if (bus.ack0 !== 1'b0 || bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL read_wait: got ack0 %b mem_req %b want 0 1", bus.ack0, bus.mem_req); end
        bus.mem_rdata = {4{32'hDEAD_BEEF}};
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.req0      = 1'b0;
        exp_resp      = {4{32'hDEAD_BEEF}};
        n_tests++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin n_fail++; $display("FAIL read_ack: got ack0 %b ack1 %b want 1 0", bus.ack0, bus.ack1); end
        n_tests++; if (bus.resp_data !== exp_resp || bus.route_sel !== 1'b0) begin n_fail++; $display("FAIL read_resp: got %h sel %b want %h 0", bus.resp_data, bus.route_sel, exp_resp); end
        tick();
        n_tests++; if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL read_ack_pulse: got %b want 0", bus.ack0); end
    endtask

    task automatic test_timeout();
        bus.addr0 = 32'h0000_0400;
        bus.req0  = 1'b1;
        tick();
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            tick();
            n_tests++; if (bus.mem_req !== 1'b1 || bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL timeout_busy[%0d]: got mem_req %b ack0 %b want 1 0", k, bus.mem_req, bus.ack0); end
        end
        tick();
        bus.req0 = 1'b0;
        exp_resp = '0;
        n_tests++; if (bus.ack0 !== 1'b1 || bus.err !== 1'b1) begin n_fail++; $display("FAIL timeout_ack_err: got ack0 %b err %b want 1 1", bus.ack0, bus.err); end
        n_tests++; if (bus.resp_data !== '0 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_resp: got %h mem_req %b want 0 0", bus.resp_data, bus.mem_req); end
        tick();
        n_tests++; if (bus.err !== 1'b0 || bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got err %b ack0 %b want 0 0", bus.err, bus.ack0); end
    endtask

    task automatic test_timeout_race();
        bus.addr0 = 32'h0000_0480;
        bus.req0  = 1'b1;
        tick();
        repeat (TIMEOUT - 1) tick();
        bus.mem_rdata = {4{32'h1357_9BDF}};
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.req0      = 1'b0;
        exp_resp      = {4{32'h1357_9BDF}};
        n_tests++; if (bus.ack0 !== 1'b1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL race_ack_err: got ack0 %b err %b want 1 0", bus.ack0, bus.err); end
        n_tests++; if (bus.resp_data !== exp_resp) begin n_fail++; $display("FAIL race_resp: got %h want %h", bus.resp_data, exp_resp); end
        tick();
    endtask

    task automatic test_stray_ready();
        bus.mem_rdata = {4{32'hFFFF_0000}};
        bus.mem_ready = 1'b1;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        n_tests++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL stray_no_ack: got ack %b%b mem_req %b want 00 0", bus.ack0, bus.ack1, bus.mem_req); end
        n_tests++; if (bus.resp_data !== exp_resp) begin n_fail++; $display("FAIL stray_resp_hold: got %h want %h", bus.resp_data, exp_resp); end
    endtask

    task automatic test_reset_mid_busy();
        bus.addr0 = 32'h0000_0500;
        bus.req0  = 1'b1;
        tick();
        tick();
        n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got mem_req %b want 1", bus.mem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== '0) begin n_fail++; $display("FAIL midrst_async: got mem_req %b addr %h want 0 0", bus.mem_req, bus.mem_addr); end
        n_tests++; if (bus.resp_data !== '0 || bus.route_sel !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got resp %h sel %b err %b want 0 0 0", bus.resp_data, bus.route_sel, bus.err); end
        bus.req0 = 1'b0;
        repeat (2) tick();
        n_tests++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin n_fail++; $display("FAIL midrst_no_ack: got %b%b want 00", bus.ack0, bus.ack1); end
        rst_n    = 1'b1;
        exp_resp = '0;
        tick();
        bus.addr0 = 32'h0000_0600;
        bus.req0  = 1'b1;
        tick();
        n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0600 || bus.route_sel !== 1'b0) begin n_fail++; $display("FAIL midrst_regrant: got req %b addr %h sel %b want 1 00000600 0", bus.mem_req, bus.mem_addr, bus.route_sel); end
        bus.mem_rdata = {4{32'h2468_ACE0}};
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.req0      = 1'b0;
        n_tests++; if (bus.ack0 !== 1'b1 || bus.resp_data !== {4{32'h2468_ACE0}}) begin n_fail++; $display("FAIL midrst_complete: got ack0 %b resp %h want 1 %h", bus.ack0, bus.resp_data, {4{32'h2468_ACE0}}); end
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.addr0     = '0;
        bus.addr1     = '0;
        bus.we0       = 1'b0;
        bus.we1       = 1'b0;
        bus.wdata0    = '0;
        bus.wdata1    = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        exp_resp      = '0;

        test_reset();
        test_round_robin();
        test_write();
        test_single_read();
        test_timeout();
        test_timeout_race();
        test_stray_ready();
        test_reset_mid_busy();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
